// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit and its helpers.
//   WORD                 data/address width
//   MEM_B/MEM_H/MEM_W    access-size encodings (2'b11 is treated as word)
//   lsu_state_e          LSU handshake FSM states
//   dcache_state_e       D-cache controller states
//   lsu_misaligned()     alignment rule for a size/address-low-bits pair
package mem_stage_lsu_pkg;

  localparam int WORD = 32;

  localparam logic [1:0] MEM_B = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;
  localparam logic [1:0] MEM_W = 2'b10;

  typedef enum logic [1:0] {
    LSU_IDLE      = 2'd0,
    LSU_WAIT_ADDR = 2'd1,
    LSU_WAIT_DATA = 2'd2,
    LSU_DISCARD   = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    DC_IDLE   = 2'd0,
    DC_LOOKUP = 2'd1,
    DC_MISS   = 2'd2,
    DC_REFILL = 2'd3
  } dcache_state_e;

  // Bytes are always aligned; halves need addr[0]=0; words (and the
  // illegal 2'b11 encoding) need addr[1:0]=0.
  function automatic logic lsu_misaligned(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
    logic r;
    case (size)
      MEM_B:   r = 1'b0;
      MEM_H:   r = addr_lo[0];
      default: r = |addr_lo;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_load_align_ext.sv
// load_align_ext: combinational load-data alignment and extension.
// Shared with the D-cache uncached path.
//   i_rdata     raw 32-bit word from the cache / bus
//   i_off       byte offset (addr[1:0]) of the access
//   i_size      MEM_B / MEM_H / MEM_W (2'b11 treated as word)
//   i_unsigned  1 = zero-extend, 0 = sign-extend
//   o_data      shifted, truncated and extended result
module load_align_ext
  import mem_stage_lsu_pkg::*;
(
  input  logic [WORD-1:0] i_rdata,
  input  logic [1:0]      i_off,
  input  logic [1:0]      i_size,
  input  logic            i_unsigned,
  output logic [WORD-1:0] o_data
);

  logic [WORD-1:0]   w_shifted;
  logic signed [7:0] w_byte;
  logic signed [15:0] w_half;

  always_comb begin
    w_shifted = i_rdata >> {i_off, 3'b000};
    w_byte    = w_shifted[7:0];
    w_half    = w_shifted[15:0];
    case (i_size)
      MEM_B: o_data = i_unsigned ? {{(WORD-8){1'b0}}, w_byte}
                                 : {{(WORD-8){w_byte[7]}}, w_byte};
      MEM_H: o_data = i_unsigned ? {{(WORD-16){1'b0}}, w_half}
                                 : {{(WORD-16){w_half[15]}}, w_half};
      default: o_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage load/store unit between EX/MEM and MEM/WB.
// Runs the valid/addr_ok/data_ok D-cache handshake, builds strobes and
// lane-replicated store data, aligns/extends load data, and produces the
// mem_stall freeze and mem_wb_flush bubble.
//   inputs : clk, rst, mem_en, mem_we, mem_size, mem_unsigned, mem_addr,
//            mem_wdata, pipe_flush, dc_addr_ok, dc_data_ok, dc_rdata
//   outputs: dc_valid, dc_op, dc_addr, dc_wstrb, dc_wdata, mem_stall,
//            mem_wb_flush, load_data, mem_done, ale
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_en,
  input  logic            mem_we,
  input  logic [1:0]      mem_size,
  input  logic            mem_unsigned,
  input  logic [WORD-1:0] mem_addr,
  input  logic [WORD-1:0] mem_wdata,
  input  logic            pipe_flush,
  output logic            dc_valid,
  output logic            dc_op,
  output logic [WORD-1:0] dc_addr,
  output logic [3:0]      dc_wstrb,
  output logic [WORD-1:0] dc_wdata,
  input  logic            dc_addr_ok,
  input  logic            dc_data_ok,
  input  logic [WORD-1:0] dc_rdata,
  output logic            mem_stall,
  output logic            mem_wb_flush,
  output logic [WORD-1:0] load_data,
  output logic            mem_done,
  output logic            ale
);

  lsu_state_e      r_state;
  logic            w_misal;
  logic            w_idle;
  logic            w_issue;
  logic            w_ale;
  logic            w_take;
  logic            w_stall;
  logic [WORD-1:0] w_ext;

  // All handshake outputs are forced quiet while rst is held so the
  // pipeline sees reset values in the reset cycle itself.
  assign w_misal = lsu_misaligned(mem_size, mem_addr[1:0]);
  assign w_idle  = (r_state == LSU_IDLE);
  assign w_issue = ~rst & w_idle & mem_en & ~w_misal & ~pipe_flush;
  assign w_ale   = ~rst & w_idle & mem_en & w_misal;
  // A flush in the data_ok cycle kills the instruction: the response is
  // consumed but never reported.
  assign w_take  = ~rst & (r_state == LSU_WAIT_DATA) & dc_data_ok & ~pipe_flush;

  assign dc_valid = w_issue | (~rst & (r_state == LSU_WAIT_ADDR) & ~pipe_flush);
  assign dc_op    = mem_we;
  assign dc_addr  = {mem_addr[WORD-1:2], 2'b00};

  always_comb begin
    case (mem_size)
      MEM_B: begin
        dc_wstrb = 4'b0001 << mem_addr[1:0];
        dc_wdata = {4{mem_wdata[7:0]}};
      end
      MEM_H: begin
        dc_wstrb = 4'b0011 << {mem_addr[1], 1'b0};
        dc_wdata = {2{mem_wdata[15:0]}};
      end
      default: begin
        dc_wstrb = 4'b1111;
        dc_wdata = mem_wdata;
      end
    endcase
  end

  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      LSU_IDLE:      w_stall = w_issue & ~dc_data_ok;
      LSU_WAIT_ADDR: w_stall = ~rst;
      LSU_WAIT_DATA: w_stall = ~rst & ~dc_data_ok;
      LSU_DISCARD:   w_stall = ~rst;
      default:       w_stall = 1'b0;
    endcase
  end

  assign mem_stall    = w_stall;
  assign mem_wb_flush = w_stall | (~rst & pipe_flush);
  // Misaligned accesses complete immediately so the exception can commit.
  assign mem_done     = w_take | (w_ale & ~pipe_flush);
  assign ale          = w_ale;

  load_align_ext u_align (
    .i_rdata    (dc_rdata),
    .i_off      (mem_addr[1:0]),
    .i_size     (mem_size),
    .i_unsigned (mem_unsigned),
    .o_data     (w_ext)
  );

  assign load_data = w_take ? w_ext : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LSU_IDLE;
    end else begin
      case (r_state)
        LSU_IDLE:
          if (w_issue) r_state <= dc_addr_ok ? LSU_WAIT_DATA : LSU_WAIT_ADDR;
        LSU_WAIT_ADDR:
          if (pipe_flush)      r_state <= LSU_IDLE;
          else if (dc_addr_ok) r_state <= LSU_WAIT_DATA;
        LSU_WAIT_DATA:
          if (dc_data_ok)      r_state <= LSU_IDLE;
          else if (pipe_flush) r_state <= LSU_DISCARD;
        LSU_DISCARD:
          if (dc_data_ok)      r_state <= LSU_IDLE;
        default: r_state <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_en = 1'b0, mem_we = 1'b0, mem_unsigned = 1'b0, pipe_flush = 1'b0;
  logic [1:0]  mem_size = 2'b00;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic        dc_addr_ok = 1'b0, dc_data_ok = 1'b0;
  logic [31:0] dc_rdata = '0;
  logic        dc_valid, dc_op, mem_stall, mem_wb_flush, mem_done, ale;
  logic [31:0] dc_addr, dc_wdata, load_data;
  logic [3:0]  dc_wstrb;

  int n_cmp = 0;
  int n_fail = 0;

  mem_stage_lsu dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_we(mem_we), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .pipe_flush(pipe_flush), .dc_valid(dc_valid), .dc_op(dc_op), .dc_addr(dc_addr),
    .dc_wstrb(dc_wstrb), .dc_wdata(dc_wdata), .dc_addr_ok(dc_addr_ok),
    .dc_data_ok(dc_data_ok), .dc_rdata(dc_rdata), .mem_stall(mem_stall),
    .mem_wb_flush(mem_wb_flush), .load_data(load_data), .mem_done(mem_done), .ale(ale)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic m_misal(input logic [1:0] sz, input logic [31:0] a);
    int nb = nbytes(sz);
    return (int'(a[1:0]) % nb) != 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] a,
                                         input logic [1:0] sz, input logic u);
    longint v;
    int nb = nbytes(sz);
    int off = int'(a[1:0]);
    v = longint'(rd) / (longint'(1) << (8 * off));
    v = v % (longint'(1) << (8 * nb));
    if (!u && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
    return v[31:0];
  endfunction

  function automatic logic [3:0] m_strb(input logic [1:0] sz, input logic [31:0] a);
    int nb = nbytes(sz);
    int base = (nb == 1) ? int'(a[1:0]) : (nb == 2) ? int'(a[1:0]) & 2 : 0;
    logic [3:0] s = '0;
    for (int i = 0; i < 4; i++) s[i] = (i >= base) && (i < base + nb);
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
    int nb = nbytes(sz);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++) r = r | (((wd >> (8 * (i % nb))) & 32'hFF) << (8 * i));
    return r;
  endfunction

  // in_flight: an access has been sent and not yet retired; accepted: the
  // cache took the address; dead: a killed access still owes a response.
  bit m_busy = 0, m_acc = 0, m_dead = 0;
  bit n_busy, n_acc, n_dead;

  always @(negedge clk) begin
    logic mis, quiet, e_issue, e_valid, e_take, e_done, e_ale, e_stall, e_flush;
    mis     = m_misal(mem_size, mem_addr);
    quiet   = !m_busy && !m_dead;
    e_issue = !rst && quiet && mem_en && !mis && !pipe_flush;
    e_valid = e_issue || (!rst && m_busy && !m_acc && !pipe_flush);
    e_take  = !rst && m_busy && m_acc && dc_data_ok && !pipe_flush;
    e_ale   = !rst && quiet && mem_en && mis;
    e_done  = e_take || (e_ale && !pipe_flush);
    e_stall = !rst && ((e_issue && !dc_data_ok) || (m_busy && !m_acc) ||
                       (m_busy && m_acc && !dc_data_ok) || m_dead);
    e_flush = e_stall || (!rst && pipe_flush);
    chk("m_dc_valid", dc_valid, e_valid);
    chk("m_mem_done", mem_done, e_done);
    chk("m_ale", ale, e_ale);
    chk("m_mem_stall", mem_stall, e_stall);
    chk("m_mem_wb_flush", mem_wb_flush, e_flush);
    if (e_valid) begin
      chk("m_dc_addr", dc_addr, mem_addr & 32'hFFFF_FFFC);
      chk("m_dc_op", dc_op, mem_we);
      if (mem_we) begin
        chk("m_dc_wstrb", dc_wstrb, m_strb(mem_size, mem_addr));
        chk("m_dc_wdata", dc_wdata, m_wdata(mem_size, mem_wdata));
      end
    end
    if (e_take && !mem_we)
      chk("m_load_data", load_data, m_load(dc_rdata, mem_addr, mem_size, mem_unsigned));
    // next-state of the model, committed at the coming edge
    n_busy = m_busy; n_acc = m_acc; n_dead = m_dead;
    if (rst) begin
      n_busy = 0; n_acc = 0; n_dead = 0;
    end else if (e_issue) begin
      n_busy = 1; n_acc = dc_addr_ok;
    end else if (m_busy && !m_acc) begin
      if (pipe_flush) n_busy = 0;
      else if (dc_addr_ok) n_acc = 1;
    end else if (m_busy && m_acc) begin
      if (dc_data_ok) begin n_busy = 0; n_acc = 0; end
      else if (pipe_flush) begin n_busy = 0; n_acc = 0; n_dead = 1; end
    end else if (m_dead && dc_data_ok) begin
      n_dead = 0;
    end
  end

  always @(posedge clk) begin
    m_busy <= n_busy; m_acc <= n_acc; m_dead <= n_dead;
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic req(input logic en, input logic we, input logic [1:0] sz,
                     input logic u, input logic [31:0] a, input logic [31:0] wd);
    mem_en = en; mem_we = we; mem_size = sz; mem_unsigned = u; mem_addr = a; mem_wdata = wd;
  endtask

  task automatic cache(input logic aok, input logic dok, input logic [31:0] rd);
    dc_addr_ok = aok; dc_data_ok = dok; dc_rdata = rd;
  endtask

  task automatic idle();
    req(0, 0, 2'b00, 0, 32'h0, 32'h0); cache(0, 0, 32'h0); pipe_flush = 0;
  endtask

  task automatic hit_load(input string nm, input logic [31:0] a, input logic [1:0] sz,
                          input logic u, input logic [31:0] rd, input logic [31:0] exp);
    req(1, 0, sz, u, a, 32'h0); cache(1, 0, 32'h0);
    @(negedge clk); chk({nm, "_stallN"}, mem_stall, 1'b1);
    step();
    cache(0, 1, rd);
    @(negedge clk);
    chk({nm, "_load"}, load_data, exp);
    chk({nm, "_done"}, mem_done, 1'b1);
    chk({nm, "_stallN1"}, mem_stall, 1'b0);
    step();
    idle();
  endtask

  initial begin
    int stalls, dones;
    idle(); rst = 1;
    step(); step();
    @(negedge clk);
    chk("rst_valid", dc_valid, 1'b0);
    rst = 0;
    step();
    @(negedge clk);
    chk("rst_stall", mem_stall, 1'b0);
    chk("rst_flush", mem_wb_flush, 1'b0);
    chk("rst_done", mem_done, 1'b0);
    chk("rst_ale", ale, 1'b0);
    chk("rst_load", load_data, 32'h0);
    step();

    hit_load("ldb", 32'h0000_1003, 2'b00, 0, 32'h80FF_0000, 32'hFFFF_FF80);
    step();
    hit_load("ldhu", 32'h0000_1002, 2'b01, 1, 32'hBEEF_1234, 32'h0000_BEEF);
    hit_load("ldh", 32'h0000_1002, 2'b01, 0, 32'hBEEF_1234, 32'hFFFF_BEEF);
    hit_load("ldw11", 32'h0000_7000, 2'b11, 0, 32'h8765_4321, 32'h8765_4321);

    // st.b
    req(1, 1, 2'b00, 0, 32'h0000_2001, 32'h0000_00AB); cache(1, 0, 32'h0);
    @(negedge clk);
    chk("stb_wstrb", dc_wstrb, 4'b0010);
    chk("stb_wdata", dc_wdata, 32'hABAB_ABAB);
    chk("stb_op", dc_op, 1'b1);
    step(); cache(0, 1, 32'h0);
    @(negedge clk); chk("stb_done", mem_done, 1'b1);
    step(); idle();

    // miss: addr_ok after 3 cycles, data_ok 5 cycles after that
    stalls = 0; dones = 0;
    for (int i = 0; i <= 8; i++) begin
      req(1, 0, 2'b10, 0, 32'h0000_4000, 32'h0);
      cache(i == 3, i == 8, (i == 8) ? 32'h1122_3344 : 32'h0);
      @(negedge clk);
      if (i <= 3) begin
        chk("miss_valid", dc_valid, 1'b1);
        chk("miss_addr", dc_addr, 32'h0000_4000);
      end
      if (mem_stall && mem_wb_flush) stalls++;
      if (mem_done) begin
        dones++;
        chk("miss_load", load_data, 32'h1122_3344);
      end
      step();
    end
    idle();
    chk("miss_stall_cycles", stalls, 8);
    chk("miss_done_count", dones, 1);

    // flush while waiting for data -> discard the late response
    req(1, 0, 2'b10, 0, 32'h0000_5000, 32'h0); cache(1, 0, 32'h0);
    step();
    cache(0, 0, 32'h0); pipe_flush = 1;
    @(negedge clk); chk("fl_done", mem_done, 1'b0); chk("fl_wbflush", mem_wb_flush, 1'b1);
    step();
    pipe_flush = 0; req(1, 0, 2'b10, 0, 32'h0000_5008, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); chk("disc_valid", dc_valid, 1'b0); chk("disc_stall", mem_stall, 1'b1);
      step();
    end
    cache(0, 1, 32'hDEAD_BEEF);
    @(negedge clk); chk("disc_done", mem_done, 1'b0); chk("disc_valid2", dc_valid, 1'b0);
    step();
    cache(1, 0, 32'h0);
    @(negedge clk); chk("after_disc_valid", dc_valid, 1'b1);
    step();
    cache(0, 1, 32'hCAFE_F00D);
    @(negedge clk); chk("after_disc_load", load_data, 32'hCAFE_F00D);
    step(); idle();

    // flush coinciding with data_ok
    req(1, 0, 2'b01, 1, 32'h0000_5102, 32'h0); cache(1, 0, 32'h0);
    step();
    cache(0, 1, 32'h1234_5678); pipe_flush = 1;
    @(negedge clk); chk("flok_done", mem_done, 1'b0);
    step(); idle();
    @(negedge clk); chk("flok_idle_stall", mem_stall, 1'b0);
    step();

    // flush before addr_ok withdraws the request
    req(1, 1, 2'b10, 0, 32'h0000_5200, 32'h1357_9BDF); cache(0, 0, 32'h0);
    step();
    pipe_flush = 1;
    @(negedge clk); chk("wa_fl_valid", dc_valid, 1'b0);
    step(); idle();
    @(negedge clk); chk("wa_fl_stall", mem_stall, 1'b0);
    step();

    // misaligned accesses
    req(1, 0, 2'b10, 0, 32'h0000_3002, 32'h0); cache(0, 0, 32'h0);
    @(negedge clk);
    chk("ale_w", ale, 1'b1); chk("ale_w_valid", dc_valid, 1'b0);
    chk("ale_w_stall", mem_stall, 1'b0); chk("ale_w_done", mem_done, 1'b1);
    step();
    req(1, 0, 2'b01, 0, 32'h0000_3001, 32'h0);
    @(negedge clk); chk("ale_h", ale, 1'b1);
    step();
    req(1, 1, 2'b01, 0, 32'h0000_3002, 32'h0000_BEEF); cache(1, 0, 32'h0);
    @(negedge clk);
    chk("sth_wstrb", dc_wstrb, 4'b1100); chk("sth_wdata", dc_wdata, 32'hBEEF_BEEF);
    chk("sth_ale", ale, 1'b0);
    step(); cache(0, 1, 32'h0);
    step(); idle();

    // reset while waiting for addr_ok
    req(1, 0, 2'b10, 0, 32'h0000_6000, 32'h0); cache(0, 0, 32'h0);
    step();
    @(negedge clk); chk("rwa_valid", dc_valid, 1'b1); chk("rwa_stall", mem_stall, 1'b1);
    step();
    rst = 1;
    @(negedge clk); chk("rwa_rst_valid", dc_valid, 1'b0);
    step();
    rst = 0; idle();
    @(negedge clk);
    chk("rwa_post_valid", dc_valid, 1'b0); chk("rwa_post_stall", mem_stall, 1'b0);
    chk("rwa_post_flush", mem_wb_flush, 1'b0); chk("rwa_post_done", mem_done, 1'b0);
    chk("rwa_post_ale", ale, 1'b0); chk("rwa_post_load", load_data, 32'h0);
    step();
    hit_load("post_rst", 32'h0000_6001, 2'b00, 1, 32'h0000_9A00, 32'h0000_009A);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
